rgb565_to_luma: RTL and testbench

//  Streaming RGB565 -> 8-bit luma (Y of BT.601 full-range YUV) converter.

---
 rtl/rgb565_to_luma.sv | 59 +++++
 tb/tb_rgb565_to_luma.sv | 114 +++++++++++
 2 files changed

// File: rtl/rgb565_to_luma.sv
// rgb565_to_luma: streaming RGB565 -> 8-bit BT.601 full-range luma, 3-clock latency.
//   sys_clk   pixel clock, rising edge
//   sys_rst_n asynchronous active-low reset
//   rgb_wr_en input pixel valid
//   rgb_in    RGB565 pixel {R5,G6,B5}
//   yuv_wr_en output sample valid
//   y_out     luma sample, held between valid cycles
// Build option RGB2YUV_ROUND_EN: add 128 before truncation (round-to-nearest).
module rgb565_to_luma #(
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rgb_wr_en,
  input  logic [15:0] rgb_in,
  output logic        yuv_wr_en,
  output logic [7:0]  y_out
);
`ifdef RGB2YUV_ROUND_EN
  localparam logic [16:0] RND = 17'd128;
`else
  localparam logic [16:0] RND = 17'd0;
`endif
  logic [2:0]  vld;
  logic [7:0]  r8, g8, b8;
  logic [15:0] pr, pg, pb;
  logic [16:0] sum;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      vld       <= '0;
      r8        <= '0;
      g8        <= '0;
      b8        <= '0;
      pr        <= '0;
      pg        <= '0;
      pb        <= '0;
      sum       <= '0;
      y_out     <= '0;
      yuv_wr_en <= 1'b0;
    end else begin
      vld       <= {vld[1:0], rgb_wr_en};
      yuv_wr_en <= vld[2];
      if (rgb_wr_en)
        {r8, g8, b8} <= {rgb_in[15:11], rgb_in[15:13], rgb_in[10:5], rgb_in[10:9],
                         rgb_in[4:0], rgb_in[4:2]};
      if (vld[0]) begin
        pr <= 16'(r8) * 16'(COEF_R);
        pg <= 16'(g8) * 16'(COEF_G);
        pb <= 16'(b8) * 16'(COEF_B);
      end
      if (vld[1])
        sum <= 17'(pr) + 17'(pg) + 17'(pb) + RND;
      // sum >= 16'hFF00 + 256 is exactly bit 16 set
      if (vld[2])
        y_out <= sum[16] ? 8'hFF : sum[15:8];
    end
endmodule

// File: tb/tb_rgb565_to_luma.sv
// tb_rgb565_to_luma: randomized and directed stimulus against a queue-based luma reference model.
module tb_rgb565_to_luma;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rgb_wr_en = 1'b0;
  logic [15:0] rgb_in = '0;
  logic        yuv_wr_en;
  logic [7:0]  y_out;
  int checks = 0, failures = 0, ec = 0, y_hold = 0;
  int q_cyc[$];
  int q_y[$];
  logic v;
`ifdef RGB2YUV_ROUND_EN
  localparam int LIT_1234 = 64, LIT_F800 = 77;
`else
  localparam int LIT_1234 = 63, LIT_F800 = 76;
`endif
  always #5 sys_clk = ~sys_clk;
  rgb565_to_luma dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rgb_wr_en(rgb_wr_en),
    .rgb_in(rgb_in), .yuv_wr_en(yuv_wr_en), .y_out(y_out)
  );
  function automatic int ref_y(logic [15:0] p);
    int r5, g6, b5, s;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    s = (r5 * 8 + r5 / 4) * 77 + (g6 * 4 + g6 / 16) * 150 + (b5 * 8 + b5 / 4) * 29;
`ifdef RGB2YUV_ROUND_EN
    s += 128;
`endif
    s /= 256;
    return s > 255 ? 255 : s;
  endfunction
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge sys_clk) begin
    ec++;
    if (sys_rst_n && rgb_wr_en) begin
      q_cyc.push_back(ec);
      q_y.push_back(ref_y(rgb_in));
    end
  end
  always @(negedge sys_clk) begin
    v = q_cyc.size() > 0 && q_cyc[0] == ec - 3;
    if (v) begin
      y_hold = q_y.pop_front();
      void'(q_cyc.pop_front());
    end
    chk("valid", int'(yuv_wr_en), int'(v));
    chk("y", int'(y_out), y_hold);
  end
  task automatic px(logic en, logic [15:0] d);
    @(negedge sys_clk);
    #2;
    rgb_wr_en = en;
    rgb_in = d;
  endtask
  task automatic idle(int n);
    repeat (n) px(1'b0, 16'($urandom));
  endtask
  task automatic do_reset();
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    rgb_wr_en = 1'b0;
    q_cyc.delete();
    q_y.delete();
    y_hold = 0;
    #1;
    chk("rst_now_y", int'(y_out), 0);
    chk("rst_now_v", int'(yuv_wr_en), 0);
    idle(5);
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
  endtask
  initial begin
    idle(6);
    chk("rst_hold_y", int'(y_out), 0);
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    idle(2);
    px(1'b1, 16'h1234);
    idle(5);
    chk("single_lit", int'(y_out), LIT_1234);
    px(1'b1, 16'h1234);
    px(1'b0, 16'hDEAD);
    px(1'b1, 16'h5678);
    idle(5);
    chk("gap_lit", int'(y_out), 168);
    px(1'b1, 16'hFFFF);
    px(1'b1, 16'h0000);
    px(1'b1, 16'hF800);
    idle(5);
    chk("extreme_lit", int'(y_out), LIT_F800);
    for (int i = 0; i < 8; i++) px(1'b1, 16'($urandom));
    idle(5);
    px(1'b1, 16'($urandom));
    px(1'b1, 16'($urandom));
    do_reset();
    idle(6);
    for (int i = 0; i < 400; i++) px(1'($urandom_range(0, 1)), 16'($urandom));
    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
